// File: rtl/control_unit_pkg.sv
// Shared definitions for the mini-CPU control sequencer: opcodes, IR field
// positions, state encoding and the control-strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_NEG  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01010;
    localparam logic [4:0] OP_DIV  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam int MEM_WAIT_MAX_DEF = 15;
    localparam int WAIT_W           = 8;
    typedef logic [WAIT_W-1:0] wait_t;

    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    typedef struct packed {
        logic        pc_out;
        logic        zhigh_out;
        logic        zlow_out;
        logic        mdr_out;
        logic        hi_out;
        logic        lo_out;
        logic        mar_in;
        logic        pc_in;
        logic        mdr_in;
        logic        ir_in;
        logic        y_in;
        logic        z_in;
        logic        hi_in;
        logic        lo_in;
        logic        inc_pc;
        logic        read;
        logic        run;
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic [4:0]  op;
    } ctrl_t;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath control interface: the sequencer (master) drives every strobe,
// the datapath (slave) supplies IR and the memory-ready handshake.
interface control_unit_if;
    logic [31:0] IR;
    logic        Mem_rdy;
    logic        PCout, Zhighout, Zlowout, MDRout, HIOut, LOout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        InPC;
    logic        Read;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [4:0]  op;
    logic        Run;

    modport master (
        input  IR, Mem_rdy,
        output PCout, Zhighout, Zlowout, MDRout, HIOut, LOout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output InPC, Read, Rout, Rin, op, Run
    );

    modport slave (
        output IR, Mem_rdy,
        input  PCout, Zhighout, Zlowout, MDRout, HIOut, LOout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  InPC, Read, Rout, Rin, op, Run
    );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational instruction decoder: opcode class flags and one-hot
// register selects taken straight from the IR fields.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  opcode,
    output logic        is_binary,
    output logic        is_unary,
    output logic        is_muldiv,
    output logic        is_nop,
    output logic        is_halt,
    output logic        is_illegal,
    output logic [15:0] ra_oh,
    output logic [15:0] rb_oh,
    output logic [15:0] rc_oh
);

    logic unused_bits_s;

    assign opcode        = ir[OPC_HI:OPC_LO];
    assign ra_oh         = onehot16(ir[RA_HI:RA_LO]);
    assign rb_oh         = onehot16(ir[RB_HI:RB_LO]);
    assign rc_oh         = onehot16(ir[RC_HI:RC_LO]);
    assign unused_bits_s = ^ir[RC_LO-1:0];

    // Classify the opcode; anything unlisted is illegal.
    always_comb begin
        is_binary  = 1'b0;
        is_unary   = 1'b0;
        is_muldiv  = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_binary = 1'b1;
            OP_MUL, OP_DIV: begin
                is_binary = 1'b1;
                is_muldiv = 1'b1;
            end
            OP_NEG, OP_NOT: is_unary = 1'b1;
            OP_NOP:         is_nop   = 1'b1;
            OP_HALT:        is_halt  = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the mini CPU (fetch, decode, ALU T-states).
// Optional macro CU_STOP_EN adds a Stop input that halts at instruction boundaries.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
    input  logic Clock,
    input  logic clear,
`ifdef CU_STOP_EN
    input  logic Stop,
`endif
    control_unit_if.master cu
);

    localparam wait_t WAIT_LAST = wait_t'(MEM_WAIT_MAX - 1);

    state_t      state_r, state_next_s;
    wait_t       wait_r, wait_next_s;
    ctrl_t       ctrl_s;
    logic        stop_s;

    logic [4:0]  opcode_s;
    logic        dec_binary_s, dec_unary_s, dec_muldiv_s;
    logic        dec_nop_s, dec_halt_s, dec_illegal_s;
    logic [15:0] ra_oh_s, rb_oh_s, rc_oh_s;

`ifdef CU_STOP_EN
    assign stop_s = Stop;
`else
    assign stop_s = 1'b0;
`endif

    instr_decode u_decode (
        .ir         (cu.IR),
        .opcode     (opcode_s),
        .is_binary  (dec_binary_s),
        .is_unary   (dec_unary_s),
        .is_muldiv  (dec_muldiv_s),
        .is_nop     (dec_nop_s),
        .is_halt    (dec_halt_s),
        .is_illegal (dec_illegal_s),
        .ra_oh      (ra_oh_s),
        .rb_oh      (rb_oh_s),
        .rc_oh      (rc_oh_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        wait_next_s  = wait_r;
        case (state_r)
            ST_RST: state_next_s = ST_T0;
            ST_T0: begin
                state_next_s = ST_T1;
                wait_next_s  = '0;
            end
            ST_T1: begin
                if (cu.Mem_rdy) begin
                    state_next_s = ST_T2;
                end else if (wait_r == WAIT_LAST) begin
                    state_next_s = ST_FAULT;
                end else begin
                    wait_next_s = wait_r + wait_t'(1);
                end
            end
            ST_T2: state_next_s = ST_T3;
            ST_T3: begin
                if (dec_illegal_s) begin
                    state_next_s = ST_FAULT;
                end else if (dec_nop_s) begin
                    state_next_s = stop_s ? ST_HALT : ST_T0;
                end else if (dec_halt_s) begin
                    state_next_s = ST_HALT;
                end else if (dec_binary_s) begin
                    state_next_s = ST_T4;
                end else if (dec_unary_s) begin
                    state_next_s = ST_T5;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            ST_T4: state_next_s = ST_T5;
            ST_T5: begin
                if (dec_muldiv_s) begin
                    state_next_s = ST_T6;
                end else begin
                    state_next_s = stop_s ? ST_HALT : ST_T0;
                end
            end
            ST_T6:    state_next_s = stop_s ? ST_HALT : ST_T0;
            ST_HALT:  state_next_s = ST_HALT;
            ST_FAULT: state_next_s = ST_FAULT;
            default:  state_next_s = ST_FAULT;
        endcase
    end

    // State register and T1 wait counter with synchronous clear.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_r <= ST_RST;
            wait_r  <= '0;
        end else begin
            state_r <= state_next_s;
            wait_r  <= wait_next_s;
        end
    end

    // Moore decode of state plus the datapath IR. The IR register is loaded on
    // the same edge that enters T3, so these strobes cannot be pre-registered.
    always_comb begin
        ctrl_s     = '0;
        ctrl_s.run = 1'b1;
        case (state_r)
            ST_RST: ctrl_s.run = 1'b1;
            ST_T0: begin
                ctrl_s.pc_out = 1'b1;
                ctrl_s.mar_in = 1'b1;
                ctrl_s.inc_pc = 1'b1;
                ctrl_s.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl_s.zlow_out = 1'b1;
                ctrl_s.pc_in    = (wait_r == '0);
                ctrl_s.read     = 1'b1;
                ctrl_s.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl_s.mdr_out = 1'b1;
                ctrl_s.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (dec_binary_s) begin
                    ctrl_s.r_out = rb_oh_s;
                    ctrl_s.y_in  = 1'b1;
                end else if (dec_unary_s) begin
                    ctrl_s.r_out = rb_oh_s;
                    ctrl_s.op    = opcode_s;
                    ctrl_s.z_in  = 1'b1;
                end else begin
                    ctrl_s.run = 1'b1;
                end
            end
            ST_T4: begin
                ctrl_s.r_out = rc_oh_s;
                ctrl_s.op    = opcode_s;
                ctrl_s.z_in  = 1'b1;
            end
            ST_T5: begin
                ctrl_s.zlow_out = 1'b1;
                if (dec_muldiv_s) begin
                    ctrl_s.lo_in = 1'b1;
                end else begin
                    ctrl_s.r_in = ra_oh_s;
                end
            end
            ST_T6: begin
                ctrl_s.zhigh_out = 1'b1;
                ctrl_s.hi_in     = 1'b1;
            end
            ST_HALT, ST_FAULT: ctrl_s.run = 1'b0;
            default:           ctrl_s.run = 1'b0;
        endcase
    end

    assign cu.PCout    = ctrl_s.pc_out;
    assign cu.Zhighout = ctrl_s.zhigh_out;
    assign cu.Zlowout  = ctrl_s.zlow_out;
    assign cu.MDRout   = ctrl_s.mdr_out;
    assign cu.HIOut    = ctrl_s.hi_out;
    assign cu.LOout    = ctrl_s.lo_out;
    assign cu.MARin    = ctrl_s.mar_in;
    assign cu.PCin     = ctrl_s.pc_in;
    assign cu.MDRin    = ctrl_s.mdr_in;
    assign cu.IRin     = ctrl_s.ir_in;
    assign cu.Yin      = ctrl_s.y_in;
    assign cu.Zin      = ctrl_s.z_in;
    assign cu.HIin     = ctrl_s.hi_in;
    assign cu.LOin     = ctrl_s.lo_in;
    assign cu.InPC     = ctrl_s.inc_pc;
    assign cu.Read     = ctrl_s.read;
    assign cu.Rout     = ctrl_s.r_out;
    assign cu.Rin      = ctrl_s.r_in;
    assign cu.op       = ctrl_s.op;
    assign cu.Run      = ctrl_s.run;

endmodule
